// File: rtl/graphics_pkg.sv
// Shared vertex/triangle types and width constants for the primitive assembly slice.
package graphics_pkg;

  localparam int ID_W    = 16;
  localparam int COORD_W = 32;
  localparam int MAT_W   = 12;

  typedef struct packed {
    logic [ID_W-1:0]              id;
    logic [2:0][COORD_W-1:0]      position;
    logic [2:0][COORD_W-1:0]      normal;
    logic [MAT_W-1:0]             material;
  } vertex_t;

  // Index 0 of each packed array is triangle corner 0.
  typedef struct packed {
    logic [2:0][ID_W-1:0]         vertex_id;
    logic [2:0][2:0][COORD_W-1:0] position;
    logic [2:0][2:0][COORD_W-1:0] normal;
    logic [MAT_W-1:0]             material;
  } triangle_t;

  typedef enum logic [1:0] {
    CORNER0 = 2'd0,
    CORNER1 = 2'd1,
    CORNER2 = 2'd2
  } corner_e;

endpackage

// File: rtl/primitive_assembly_if.sv
// Vertex-in / triangle-out bus of primitive_assembly; slave is the block, master the producer/consumer side.
interface primitive_assembly_if;
  import graphics_pkg::*;

  logic                         valid_in;
  logic                         ready_out;
  logic [ID_W-1:0]              vertex_id_in;
  logic [2:0][COORD_W-1:0]      position_in;
  logic [2:0][COORD_W-1:0]      normal_in;
  logic [MAT_W-1:0]             material_in;
  logic                         flush_in;

  logic                         valid_out;
  logic                         ready_in;
  logic [2:0][ID_W-1:0]         vertex_id_out;
  logic [2:0][2:0][COORD_W-1:0] position_out;
  logic [2:0][2:0][COORD_W-1:0] normal_out;
  logic [MAT_W-1:0]             material_out;

  logic                         overflow_out;
  logic [15:0]                  tri_count_out;

  modport slave (
    input  valid_in, vertex_id_in, position_in, normal_in, material_in, flush_in, ready_in,
    output ready_out, valid_out, vertex_id_out, position_out, normal_out, material_out,
           overflow_out, tri_count_out
  );

  modport master (
    output valid_in, vertex_id_in, position_in, normal_in, material_in, flush_in, ready_in,
    input  ready_out, valid_out, vertex_id_out, position_out, normal_out, material_out,
           overflow_out, tri_count_out
  );

endinterface

// File: rtl/triangle_fifo.sv
// Synchronous FIFO of triangle_t; DEPTH must be a power of two so pointers wrap naturally.
module triangle_fifo
  import graphics_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk_in,
  input  logic      rst_n_in,
  input  logic      push,
  input  triangle_t push_data,
  input  logic      pop,
  output triangle_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  triangle_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; stale entries are unreachable once the pointers are cleared.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/primitive_assembly.sv
// Collects accepted vertices into triangles (corners 0,1,2) and queues them in triangle_fifo.
// Build option PRIM_DEGENERATE_CULL_EN: triangles whose three vertex ids are not distinct are dropped.
module primitive_assembly
  import graphics_pkg::*;
#(
  parameter int OUT_DEPTH = 2
) (
  input logic                 clk_in,
  input logic                 rst_n_in,
  primitive_assembly_if.slave pa
);

  corner_e     corner_q;
  corner_e     corner_d;
  corner_e     corner_base;
  vertex_t     vtx_in;
  vertex_t     slot0_p0;
  vertex_t     slot1_p0;
  triangle_t   tri_p0;
  triangle_t   tri_out;
  logic        accept;
  logic        load0;
  logic        load1;
  logic        complete;
  logic        keep_p0;
  logic        vld_p0;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        overflow_q;
  logic [15:0] tri_count_q;

  always_comb begin
    vtx_in          = '0;
    vtx_in.id       = pa.vertex_id_in;
    vtx_in.position = pa.position_in;
    vtx_in.normal   = pa.normal_in;
    vtx_in.material = pa.material_in;
  end

  // Readiness comes only from the registered FIFO count.
  assign accept = pa.valid_in && !fifo_full;
  assign pop    = !fifo_empty && pa.ready_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) corner_q <= CORNER0;
    else           corner_q <= corner_d;
  end

  // A flush rewinds to corner 0 before the same-cycle vertex is placed.
  always_comb begin
    corner_base = pa.flush_in ? CORNER0 : corner_q;
    corner_d    = corner_base;
    if (accept) begin
      case (corner_base)
        CORNER0: corner_d = CORNER1;
        CORNER1: corner_d = CORNER2;
        default: corner_d = CORNER0;
      endcase
    end
  end

  always_comb begin
    load0    = accept && (corner_base == CORNER0);
    load1    = accept && (corner_base == CORNER1);
    complete = accept && (corner_base == CORNER2);
  end

  always_ff @(posedge clk_in) begin
    if (load0) slot0_p0 <= vtx_in;
    if (load1) slot1_p0 <= vtx_in;
  end

  // ---- stage p0: triangle assembled from the two slots and the live vertex ----
  always_comb begin
    tri_p0              = '0;
    tri_p0.vertex_id[0] = slot0_p0.id;
    tri_p0.vertex_id[1] = slot1_p0.id;
    tri_p0.vertex_id[2] = vtx_in.id;
    tri_p0.position[0]  = slot0_p0.position;
    tri_p0.position[1]  = slot1_p0.position;
    tri_p0.position[2]  = vtx_in.position;
    tri_p0.normal[0]    = slot0_p0.normal;
    tri_p0.normal[1]    = slot1_p0.normal;
    tri_p0.normal[2]    = vtx_in.normal;
    tri_p0.material     = slot0_p0.material;
  end

`ifdef PRIM_DEGENERATE_CULL_EN
  assign keep_p0 = (slot0_p0.id != slot1_p0.id) &&
                   (slot0_p0.id != vtx_in.id)   &&
                   (slot1_p0.id != vtx_in.id);
`else
  assign keep_p0 = 1'b1;
`endif

  assign vld_p0 = complete && keep_p0;

  triangle_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .push      (vld_p0),
    .push_data (tri_p0),
    .pop       (pop),
    .pop_data  (tri_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      overflow_q  <= 1'b0;
      tri_count_q <= '0;
    end else begin
      if (pa.valid_in && fifo_full) overflow_q <= 1'b1;
      if (pop) tri_count_q <= tri_count_q + 16'd1;
    end
  end

  // ---- stage p1: FIFO head drives the triangle port ----
  assign pa.ready_out     = !fifo_full;
  assign pa.valid_out     = !fifo_empty;
  assign pa.vertex_id_out = tri_out.vertex_id;
  assign pa.position_out  = tri_out.position;
  assign pa.normal_out    = tri_out.normal;
  assign pa.material_out  = tri_out.material;
  assign pa.overflow_out  = overflow_q;
  assign pa.tri_count_out = tri_count_q;

endmodule

// File: tb/tb_primitive_assembly.sv
// Randomized and directed bench for primitive_assembly against a queue-based triangle model.
// Follows PRIM_DEGENERATE_CULL_EN the same way the design does.
module tb_primitive_assembly;
  import graphics_pkg::*;

  localparam int OUT_DEPTH = 2;
  localparam int TW        = $bits(triangle_t);

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b1;

  primitive_assembly_if pa_if ();

  primitive_assembly #(
    .OUT_DEPTH (OUT_DEPTH)
  ) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .pa       (pa_if)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: vertices of the open triangle and triangles waiting downstream.
  vertex_t     part_q[$];
  triangle_t   exp_q[$];
  bit          m_ovf;
  logic [15:0] m_cnt;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic vertex_t mk_vertex(input logic [15:0] id);
    vertex_t v;
    v.id = id;
    for (int k = 0; k < 3; k++) begin
      v.position[k] = $urandom;
      v.normal[k]   = $urandom;
    end
    v.material = 12'($urandom);
    return v;
  endfunction

  function automatic bit is_degenerate(input vertex_t a, input vertex_t b, input vertex_t c);
`ifdef PRIM_DEGENERATE_CULL_EN
    return (a.id == b.id) || (a.id == c.id) || (b.id == c.id);
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_idle();
    pa_if.valid_in     = 1'b0;
    pa_if.vertex_id_in = '0;
    pa_if.position_in  = '0;
    pa_if.normal_in    = '0;
    pa_if.material_in  = '0;
    pa_if.flush_in     = 1'b0;
    pa_if.ready_in     = 1'b0;
  endtask

  task automatic model_clear();
    part_q.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_cnt = '0;
  endtask

  task automatic check_outputs();
    triangle_t got;
    check_eq("ready_out", TW'(pa_if.ready_out), TW'(exp_q.size() < OUT_DEPTH));
    check_eq("valid_out", TW'(pa_if.valid_out), TW'(exp_q.size() != 0));
    check_eq("overflow_out", TW'(pa_if.overflow_out), TW'(m_ovf));
    check_eq("tri_count_out", TW'(pa_if.tri_count_out), TW'(m_cnt));
    if (exp_q.size() != 0) begin
      got.vertex_id = pa_if.vertex_id_out;
      got.position  = pa_if.position_out;
      got.normal    = pa_if.normal_out;
      got.material  = pa_if.material_out;
      check_eq("triangle", got, exp_q[0]);
    end
  endtask

  // One clock cycle: drive at negedge, check registered outputs, then advance the model.
  task automatic step(input bit v, input logic [15:0] id, input bit fl, input bit rdy);
    vertex_t   vx;
    triangle_t t;
    bit        can_take;
    vx = mk_vertex(id);
    @(negedge clk_in);
    pa_if.valid_in     = v;
    pa_if.vertex_id_in = vx.id;
    pa_if.position_in  = vx.position;
    pa_if.normal_in    = vx.normal;
    pa_if.material_in  = vx.material;
    pa_if.flush_in     = fl;
    pa_if.ready_in     = rdy;
    #1;
    check_outputs();
    can_take = (exp_q.size() < OUT_DEPTH);
    if (exp_q.size() != 0 && rdy) begin
      void'(exp_q.pop_front());
      m_cnt = m_cnt + 16'd1;
    end
    if (fl) part_q.delete();
    if (v && can_take) begin
      part_q.push_back(vx);
      if (part_q.size() == 3) begin
        if (!is_degenerate(part_q[0], part_q[1], part_q[2])) begin
          for (int k = 0; k < 3; k++) begin
            t.vertex_id[k] = part_q[k].id;
            t.position[k]  = part_q[k].position;
            t.normal[k]    = part_q[k].normal;
          end
          t.material = part_q[0].material;
          exp_q.push_back(t);
        end
        part_q.delete();
      end
    end else if (v) begin
      m_ovf = 1'b1;
    end
  endtask

  // Asynchronous reset asserted away from the clock edge; outputs must clear at once.
  task automatic do_reset();
    @(posedge clk_in);
    #2;
    set_idle();
    rst_n_in = 1'b0;
    model_clear();
    #1;
    check_eq("rst_valid_out", TW'(pa_if.valid_out), TW'(0));
    check_eq("rst_ready_out", TW'(pa_if.ready_out), TW'(1));
    check_eq("rst_overflow_out", TW'(pa_if.overflow_out), TW'(0));
    check_eq("rst_tri_count_out", TW'(pa_if.tri_count_out), TW'(0));
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 16'd0, 1'b0, rdy);
  endtask

  initial begin
    logic [15:0] base;
    set_idle();
    model_clear();
    #1;
    do_reset();

    // Two back-to-back triangles with the consumer always ready.
    for (int i = 0; i < 6; i++) step(1'b1, 16'(i), 1'b0, 1'b1);
    idle(3, 1'b1);
    check_eq("two_tris_count", TW'(pa_if.tri_count_out), TW'(2));

    // Backpressure: FIFO fills after six vertices, the rest are dropped.
    base = pa_if.tri_count_out;
    for (int i = 1; i <= 9; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    check_eq("bp_overflow", TW'(pa_if.overflow_out), TW'(1));
    idle(6, 1'b1);
    check_eq("bp_delivered", TW'(pa_if.tri_count_out), TW'(base + 16'd2));

    // Flush discards a partial triangle; flush with a vertex makes it corner 0.
    step(1'b1, 16'd10, 1'b0, 1'b1);
    step(1'b1, 16'd11, 1'b0, 1'b1);
    step(1'b0, 16'd0, 1'b1, 1'b1);
    step(1'b1, 16'd12, 1'b0, 1'b1);
    step(1'b1, 16'd13, 1'b0, 1'b1);
    step(1'b1, 16'd14, 1'b0, 1'b1);
    step(1'b1, 16'd20, 1'b1, 1'b1);
    step(1'b1, 16'd21, 1'b0, 1'b1);
    step(1'b1, 16'd22, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Repeated-id triangle followed by a clean one.
    step(1'b1, 16'd7, 1'b0, 1'b1);
    step(1'b1, 16'd7, 1'b0, 1'b1);
    step(1'b1, 16'd8, 1'b0, 1'b1);
    step(1'b1, 16'd1, 1'b0, 1'b1);
    step(1'b1, 16'd2, 1'b0, 1'b1);
    step(1'b1, 16'd3, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Reset with one triangle queued and corner 1 open.
    for (int i = 0; i < 4; i++) step(1'b1, 16'(40 + i), 1'b0, 1'b0);
    idle(1, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 16'(i), 1'b0, 1'b1);
    idle(3, 1'b1);

    // Random traffic with alternating backpressure phases and one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      bit rdy;
      if (i == 1500) do_reset();
      rdy = ((i / 250) % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      step($urandom_range(0, 9) < 7, 16'($urandom_range(0, 5)),
           $urandom_range(0, 24) == 0, rdy);
    end
    idle(6, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
